id_stage: RTL and testbench
===========================

Name: id_stage

Overview:
- Parametrised instruction-decode stage for the MIPS R2000 five-stage pipeline; successor to the bare ID stub.
- Contains the register file with write-through bypass, field extraction, control decode, immediate extension, load-use hazard detection and the ID/EX pipeline register with stall and flush.
- Sits between the IF/ID register and EX; write-back arrives from WB.

Parameters:
- DATA_W, 32, datapath and register width in bits; instruction word stays 32 bits.
- NREGS, 32, number of architectural registers; must be a power of two, at most 32.
- REG_AW, $clog2(NREGS), register address width; derived, not overridden.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- inst_in  in  32  instruction from IF/ID.
- pc_in  in  DATA_W  PC+4 of inst_in.
- valid_in  in  1  inst_in is a real instruction.
- flush_in  in  1  branch/jump resolved taken; kill the instruction in ID.
- wb_we_in  in  1  register-file write enable.
- wb_addr_in  in  REG_AW  write address.
- wb_data_in  in  DATA_W  write data.
- ex_memread_in  in  1  instruction currently in EX is a load.
- ex_rt_in  in  REG_AW  destination of that load.
- stall_out  out  1  hold PC and IF/ID this cycle (combinational).
- rs_data_out  out  DATA_W  registered rs operand.
- rt_data_out  out  DATA_W  registered rt operand.
- imm_out  out  DATA_W  registered extended immediate.
- pc_out  out  DATA_W  registered pc_in.
- rs_out, rt_out, rd_out  out  REG_AW each  registered register specifiers.
- ctrl_out  out  ctrl_t  registered control bundle.
- valid_out  out  1  ID/EX slot holds a real instruction.
- illegal_out  out  1  registered; opcode or funct was unrecognised.

Behaviour:
- Reset (rst_n=0 at a rising edge): all registered outputs go to 0 and all NREGS registers are cleared. Reset takes priority over every other input, including an in-flight write-back or stall. stall_out is 0 whenever valid_in=0.
- Register file: one write per cycle at the clock edge. Register 0 is never written and always reads 0.
- Write-through bypass: if wb_we_in=1, wb_addr_in equals the read address, and that address is non-zero, the read returns wb_data_in in the same cycle.
- Field use: only the low REG_AW bits of the rs, rt and rd fields are used.
- Decode, keyed on opcode:
  - 0x00 R-type: ALU op taken from funct (add, sub, and, or, slt); reg_dst=rd.
  - 0x08 addi and 0x23 lw: reg_dst=rt.
  - 0x2B sw: no register write.
  - 0x04 beq: branch.
  - 0x02 j: jump.
  - 0x0C andi and 0x0D ori: zero-extend the immediate.
  - All other opcodes sign-extend the immediate, truncated or extended to DATA_W.
- Illegal instructions: any other opcode, or an unknown R-type funct, produces ctrl=0 (no write, no memory access) and illegal_out=1.
- Load-use hazard: stall_out=1 when all of the following hold:
  - valid_in=1;
  - ex_memread_in=1 and ex_rt_in!=0;
  - ex_rt_in equals rs, or ex_rt_in equals rt and the instruction reads rt (R-type, sw, beq).
- ID/EX update at each edge, highest priority first:
  - reset;
  - flush_in=1 or stall_out=1: insert a bubble (valid_out=0, ctrl_out=0, illegal_out=0; data fields may update);
  - otherwise capture the decode of inst_in with valid_out=valid_in.
- flush_in and stall_out in the same cycle: the flush wins and stall_out stays asserted. The upstream stage ignores the stall when it flushes.
- Latency: 1 cycle from inst_in to outputs; there is no back-pressure beyond stall_out.

Decomposition:
- Package id_pkg holds:
  - opcode and funct localparams;
  - alu_op_e enum;
  - ctrl_t packed struct: reg_write, reg_dst, alu_src, alu_op, mem_read, mem_write, mem_to_reg, branch, jump.
- Sub-module regfile (parameters DATA_W and NREGS; two read ports, one write port, bypass, reset clear).
- Decode logic and the pipeline register stay in id_stage.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with wb_we_in=1 to r5, then release → all outputs 0, valid_out=0; reading r5 returns 0.
- Write/bypass: write 0xDEADBEEF to r3 while inst_in=add r4,r3,r3 → next cycle rs_data_out=rt_data_out=0xDEADBEEF.
- Zero register: write 0x1234 to r0, then read r0 → 0x00000000.
- Immediates: addi imm 0xFFF0 → imm_out=0xFFFFFFF0; ori imm 0xFFF0 → imm_out=0x0000FFF0.
- Load-use: ex_memread_in=1, ex_rt_in=7, inst_in=add r1,r7,r2 → stall_out=1, next cycle valid_out=0 and ctrl_out=0. Repeat with sw using r7 in the rt position → stall. With ex_rt_in=0 → no stall.
- Flush and illegal: flush_in=1 together with a valid lw → bubble. Opcode 0x3F → illegal_out=1, ctrl_out=0, valid_out=1. Repeat with DATA_W=64, NREGS=16.

Source files
------------

// File: rtl/id_pkg.sv
// Shared encodings for the decode stage: MIPS opcode/funct values, ALU operations and
// the control bundle carried through ID/EX.
package id_pkg;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpAndi  = 6'h0C;
  localparam logic [5:0] OpOri   = 6'h0D;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  localparam logic [5:0] FnAdd = 6'h20;
  localparam logic [5:0] FnSub = 6'h22;
  localparam logic [5:0] FnAnd = 6'h24;
  localparam logic [5:0] FnOr  = 6'h25;
  localparam logic [5:0] FnSlt = 6'h2A;

  typedef enum logic [2:0] {
    AluAdd = 3'd0,
    AluSub = 3'd1,
    AluAnd = 3'd2,
    AluOr  = 3'd3,
    AluSlt = 3'd4
  } alu_op_e;

  typedef struct packed {
    logic    reg_write;
    logic    reg_dst;     // 1: write rd, 0: write rt
    logic    alu_src;     // 1: second ALU operand is the immediate
    alu_op_e alu_op;
    logic    mem_read;
    logic    mem_write;
    logic    mem_to_reg;
    logic    branch;
    logic    jump;
  } ctrl_t;

endpackage

// File: rtl/regfile.sv
// Architectural register file: two read ports, one write port, write-through bypass
// and synchronous clear. Register 0 reads as zero and ignores writes.
module regfile #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NREGS  = 32,
  localparam int unsigned REG_AW = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [REG_AW-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [REG_AW-1:0] raddr_a_i,
  input  logic [REG_AW-1:0] raddr_b_i,
  output logic [DATA_W-1:0] rdata_a_o,
  output logic [DATA_W-1:0] rdata_b_o
);

  logic [DATA_W-1:0] mem_q [NREGS];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != '0)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata_a_o = mem_q[raddr_a_i];
    if (raddr_a_i == '0) begin
      rdata_a_o = '0;
    end else if (we_i && (waddr_i == raddr_a_i)) begin
      rdata_a_o = wdata_i;
    end
  end

  always_comb begin
    rdata_b_o = mem_q[raddr_b_i];
    if (raddr_b_i == '0) begin
      rdata_b_o = '0;
    end else if (we_i && (waddr_i == raddr_b_i)) begin
      rdata_b_o = wdata_i;
    end
  end

endmodule

// File: rtl/id_stage.sv
// MIPS R2000 instruction-decode stage: register read, control decode, immediate
// extension, load-use hazard detection and the ID/EX pipeline register.
module id_stage
  import id_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NREGS  = 32,
  localparam int unsigned REG_AW = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       inst_in,
  input  logic [DATA_W-1:0] pc_in,
  input  logic              valid_in,
  input  logic              flush_in,
  input  logic              wb_we_in,
  input  logic [REG_AW-1:0] wb_addr_in,
  input  logic [DATA_W-1:0] wb_data_in,
  input  logic              ex_memread_in,
  input  logic [REG_AW-1:0] ex_rt_in,
  output logic              stall_out,
  output logic [DATA_W-1:0] rs_data_out,
  output logic [DATA_W-1:0] rt_data_out,
  output logic [DATA_W-1:0] imm_out,
  output logic [DATA_W-1:0] pc_out,
  output logic [REG_AW-1:0] rs_out,
  output logic [REG_AW-1:0] rt_out,
  output logic [REG_AW-1:0] rd_out,
  output ctrl_t             ctrl_out,
  output logic              valid_out,
  output logic              illegal_out
);

  logic [5:0]        opcode;
  logic [5:0]        funct;
  logic [15:0]       imm16;
  logic [REG_AW-1:0] rs, rt, rd;

  assign opcode = inst_in[31:26];
  assign funct  = inst_in[5:0];
  assign imm16  = inst_in[15:0];
  assign rs     = inst_in[21 +: REG_AW];
  assign rt     = inst_in[16 +: REG_AW];
  assign rd     = inst_in[11 +: REG_AW];

  // Shamt, jump target and register-field bits above REG_AW are not consumed here.
  logic unused_fields;
  assign unused_fields = ^inst_in[25:6];

  logic [DATA_W-1:0] rs_data, rt_data;

  regfile #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS)
  ) u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .we_i      (wb_we_in),
    .waddr_i   (wb_addr_in),
    .wdata_i   (wb_data_in),
    .raddr_a_i (rs),
    .raddr_b_i (rt),
    .rdata_a_o (rs_data),
    .rdata_b_o (rt_data)
  );

  ctrl_t ctrl_dec;
  logic  illegal_dec;
  logic  zero_ext;
  logic  reads_rt;

  always_comb begin
    ctrl_dec    = '0;
    illegal_dec = 1'b0;
    zero_ext    = 1'b0;
    reads_rt    = 1'b0;
    case (opcode)
      OpRtype: begin
        reads_rt           = 1'b1;
        ctrl_dec.reg_write = 1'b1;
        ctrl_dec.reg_dst   = 1'b1;
        case (funct)
          FnAdd:   ctrl_dec.alu_op = AluAdd;
          FnSub:   ctrl_dec.alu_op = AluSub;
          FnAnd:   ctrl_dec.alu_op = AluAnd;
          FnOr:    ctrl_dec.alu_op = AluOr;
          FnSlt:   ctrl_dec.alu_op = AluSlt;
          default: begin
            ctrl_dec    = '0;
            illegal_dec = 1'b1;
          end
        endcase
      end
      OpAddi: begin
        ctrl_dec.reg_write = 1'b1;
        ctrl_dec.alu_src   = 1'b1;
        ctrl_dec.alu_op    = AluAdd;
      end
      OpLw: begin
        ctrl_dec.reg_write  = 1'b1;
        ctrl_dec.alu_src    = 1'b1;
        ctrl_dec.alu_op     = AluAdd;
        ctrl_dec.mem_read   = 1'b1;
        ctrl_dec.mem_to_reg = 1'b1;
      end
      OpSw: begin
        reads_rt           = 1'b1;
        ctrl_dec.alu_src   = 1'b1;
        ctrl_dec.alu_op    = AluAdd;
        ctrl_dec.mem_write = 1'b1;
      end
      OpBeq: begin
        reads_rt        = 1'b1;
        ctrl_dec.alu_op = AluSub;
        ctrl_dec.branch = 1'b1;
      end
      OpJ: begin
        ctrl_dec.jump = 1'b1;
      end
      OpAndi: begin
        zero_ext           = 1'b1;
        ctrl_dec.reg_write = 1'b1;
        ctrl_dec.alu_src   = 1'b1;
        ctrl_dec.alu_op    = AluAnd;
      end
      OpOri: begin
        zero_ext           = 1'b1;
        ctrl_dec.reg_write = 1'b1;
        ctrl_dec.alu_src   = 1'b1;
        ctrl_dec.alu_op    = AluOr;
      end
      default: begin
        illegal_dec = 1'b1;
      end
    endcase
  end

  logic [DATA_W-1:0] imm_ext;
  assign imm_ext = zero_ext ? DATA_W'(imm16) : DATA_W'($signed(imm16));

  // Load in EX writes a register this instruction reads: hold one cycle.
  assign stall_out = valid_in && ex_memread_in && (ex_rt_in != '0) &&
                     ((ex_rt_in == rs) || (reads_rt && (ex_rt_in == rt)));

  logic [DATA_W-1:0] rs_data_q, rt_data_q, imm_q, pc_q;
  logic [REG_AW-1:0] rs_q, rt_q, rd_q;
  ctrl_t             ctrl_q;
  logic              valid_q, illegal_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      pc_q      <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
      ctrl_q    <= '0;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      rs_data_q <= rs_data;
      rt_data_q <= rt_data;
      imm_q     <= imm_ext;
      pc_q      <= pc_in;
      rs_q      <= rs;
      rt_q      <= rt;
      rd_q      <= rd;
      if (flush_in || stall_out) begin
        ctrl_q    <= '0;
        valid_q   <= 1'b0;
        illegal_q <= 1'b0;
      end else begin
        ctrl_q    <= ctrl_dec;
        valid_q   <= valid_in;
        illegal_q <= illegal_dec;
      end
    end
  end

  assign rs_data_out = rs_data_q;
  assign rt_data_out = rt_data_q;
  assign imm_out     = imm_q;
  assign pc_out      = pc_q;
  assign rs_out      = rs_q;
  assign rt_out      = rt_q;
  assign rd_out      = rd_q;
  assign ctrl_out    = ctrl_q;
  assign valid_out   = valid_q;
  assign illegal_out = illegal_q;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: default 32-bit/32-register instance and a 64-bit/16-register
// instance driven side by side from the same stimulus.
module tb_id_stage;
  import id_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [31:0] inst;
  logic [63:0] pc;
  logic        valid, flush, wb_we, ex_memread;
  logic [4:0]  wb_addr, ex_rt;
  logic [63:0] wb_data;

  logic        a_stall, a_valid, a_illegal;
  logic [31:0] a_rs_data, a_rt_data, a_imm, a_pc;
  logic [4:0]  a_rs, a_rt, a_rd;
  ctrl_t       a_ctrl;

  logic        b_stall, b_valid, b_illegal;
  logic [63:0] b_rs_data, b_rt_data, b_imm, b_pc;
  logic [3:0]  b_rs, b_rt, b_rd;
  ctrl_t       b_ctrl;

  id_stage u_dut_a (
    .clk           (clk),
    .rst_n         (rst_n),
    .inst_in       (inst),
    .pc_in         (pc[31:0]),
    .valid_in      (valid),
    .flush_in      (flush),
    .wb_we_in      (wb_we),
    .wb_addr_in    (wb_addr),
    .wb_data_in    (wb_data[31:0]),
    .ex_memread_in (ex_memread),
    .ex_rt_in      (ex_rt),
    .stall_out     (a_stall),
    .rs_data_out   (a_rs_data),
    .rt_data_out   (a_rt_data),
    .imm_out       (a_imm),
    .pc_out        (a_pc),
    .rs_out        (a_rs),
    .rt_out        (a_rt),
    .rd_out        (a_rd),
    .ctrl_out      (a_ctrl),
    .valid_out     (a_valid),
    .illegal_out   (a_illegal)
  );

  id_stage #(
    .DATA_W (64),
    .NREGS  (16)
  ) u_dut_b (
    .clk           (clk),
    .rst_n         (rst_n),
    .inst_in       (inst),
    .pc_in         (pc),
    .valid_in      (valid),
    .flush_in      (flush),
    .wb_we_in      (wb_we),
    .wb_addr_in    (wb_addr[3:0]),
    .wb_data_in    (wb_data),
    .ex_memread_in (ex_memread),
    .ex_rt_in      (ex_rt[3:0]),
    .stall_out     (b_stall),
    .rs_data_out   (b_rs_data),
    .rt_data_out   (b_rt_data),
    .imm_out       (b_imm),
    .pc_out        (b_pc),
    .rs_out        (b_rs),
    .rt_out        (b_rt),
    .rd_out        (b_rd),
    .ctrl_out      (b_ctrl),
    .valid_out     (b_valid),
    .illegal_out   (b_illegal)
  );

  localparam ctrl_t CtrlAdd = '{reg_write: 1'b1, reg_dst: 1'b1, alu_src: 1'b0, alu_op: AluAdd,
                                mem_read: 1'b0, mem_write: 1'b0, mem_to_reg: 1'b0,
                                branch: 1'b0, jump: 1'b0};
  localparam ctrl_t CtrlAddi = '{reg_write: 1'b1, reg_dst: 1'b0, alu_src: 1'b1, alu_op: AluAdd,
                                 mem_read: 1'b0, mem_write: 1'b0, mem_to_reg: 1'b0,
                                 branch: 1'b0, jump: 1'b0};
  localparam ctrl_t CtrlOri = '{reg_write: 1'b1, reg_dst: 1'b0, alu_src: 1'b1, alu_op: AluOr,
                                mem_read: 1'b0, mem_write: 1'b0, mem_to_reg: 1'b0,
                                branch: 1'b0, jump: 1'b0};
  localparam ctrl_t CtrlSub = '{reg_write: 1'b1, reg_dst: 1'b1, alu_src: 1'b0, alu_op: AluSub,
                                mem_read: 1'b0, mem_write: 1'b0, mem_to_reg: 1'b0,
                                branch: 1'b0, jump: 1'b0};

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rtype(input int unsigned rs, input int unsigned rt,
                                        input int unsigned rd, input logic [5:0] fn);
    return {6'h00, rs[4:0], rt[4:0], rd[4:0], 5'h00, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input int unsigned rs,
                                        input int unsigned rt, input logic [15:0] imm);
    return {op, rs[4:0], rt[4:0], imm};
  endfunction

  initial begin
    rst_n      = 1'b0;
    inst       = '0;
    pc         = '0;
    valid      = 1'b0;
    flush      = 1'b0;
    wb_we      = 1'b1;
    wb_addr    = 5'd5;
    wb_data    = 64'hAAAA_5555;
    ex_memread = 1'b0;
    ex_rt      = 5'd0;
    step();
    step();
    rst_n = 1'b1;
    wb_we = 1'b0;
    #1;
    check("rst.a_valid", 64'(a_valid), 64'd0);
    check("rst.a_ctrl", 64'(a_ctrl), 64'd0);
    check("rst.a_rs_data", 64'(a_rs_data), 64'd0);
    check("rst.a_imm", 64'(a_imm), 64'd0);
    check("rst.a_pc", 64'(a_pc), 64'd0);
    check("rst.a_illegal", 64'(a_illegal), 64'd0);
    check("rst.b_valid", 64'(b_valid), 64'd0);
    check("rst.b_rt_data", b_rt_data, 64'd0);
    check("rst.a_stall", 64'(a_stall), 64'd0);

    // r5 was written during reset; reset must win
    inst  = rtype(5, 5, 1, FnAdd);
    valid = 1'b1;
    pc    = 64'h0000_0001_0040_0004;
    step();
    check("r5.a_rs_data", 64'(a_rs_data), 64'd0);
    check("r5.b_rs_data", b_rs_data, 64'd0);
    check("r5.a_valid", 64'(a_valid), 64'd1);
    check("r5.a_ctrl", 64'(a_ctrl), 64'(CtrlAdd));
    check("r5.a_rd", 64'(a_rd), 64'd1);
    check("r5.a_pc", 64'(a_pc), 64'h0040_0004);
    check("r5.b_pc", b_pc, 64'h0000_0001_0040_0004);

    // write-through bypass
    wb_we   = 1'b1;
    wb_addr = 5'd3;
    wb_data = 64'h1122_3344_DEAD_BEEF;
    inst    = rtype(3, 3, 4, FnAdd);
    step();
    check("byp.a_rs_data", 64'(a_rs_data), 64'hDEAD_BEEF);
    check("byp.a_rt_data", 64'(a_rt_data), 64'hDEAD_BEEF);
    check("byp.b_rs_data", b_rs_data, 64'h1122_3344_DEAD_BEEF);
    check("byp.a_rd", 64'(a_rd), 64'd4);
    check("byp.b_rd", 64'(b_rd), 64'd4);

    // stored value
    wb_we = 1'b0;
    inst  = rtype(3, 0, 4, FnAdd);
    step();
    check("rd3.a_rs_data", 64'(a_rs_data), 64'hDEAD_BEEF);
    check("rd3.b_rs_data", b_rs_data, 64'h1122_3344_DEAD_BEEF);
    check("rd3.a_rt_data", 64'(a_rt_data), 64'd0);

    // r0 ignores writes, including bypass
    wb_we   = 1'b1;
    wb_addr = 5'd0;
    wb_data = 64'h1234;
    inst    = rtype(0, 0, 2, FnAdd);
    step();
    check("r0byp.a_rs_data", 64'(a_rs_data), 64'd0);
    check("r0byp.b_rt_data", b_rt_data, 64'd0);
    wb_we = 1'b0;
    step();
    check("r0.a_rs_data", 64'(a_rs_data), 64'd0);
    check("r0.b_rs_data", b_rs_data, 64'd0);

    // immediates
    inst = itype(OpAddi, 0, 2, 16'hFFF0);
    step();
    check("addi.a_imm", 64'(a_imm), 64'hFFFF_FFF0);
    check("addi.b_imm", b_imm, 64'hFFFF_FFFF_FFFF_FFF0);
    check("addi.a_ctrl", 64'(a_ctrl), 64'(CtrlAddi));
    check("addi.a_rt", 64'(a_rt), 64'd2);
    inst = itype(OpOri, 0, 2, 16'hFFF0);
    step();
    check("ori.a_imm", 64'(a_imm), 64'h0000_FFF0);
    check("ori.b_imm", b_imm, 64'h0000_0000_0000_FFF0);
    check("ori.a_ctrl", 64'(a_ctrl), 64'(CtrlOri));

    // load-use on rs
    ex_memread = 1'b1;
    ex_rt      = 5'd7;
    inst       = rtype(7, 2, 1, FnAdd);
    #1;
    check("lu_rs.a_stall", 64'(a_stall), 64'd1);
    check("lu_rs.b_stall", 64'(b_stall), 64'd1);
    step();
    check("lu_rs.a_valid", 64'(a_valid), 64'd0);
    check("lu_rs.a_ctrl", 64'(a_ctrl), 64'd0);
    check("lu_rs.b_valid", 64'(b_valid), 64'd0);

    // load-use on rt of sw
    inst = itype(OpSw, 2, 7, 16'h0004);
    #1;
    check("lu_sw.a_stall", 64'(a_stall), 64'd1);
    step();
    check("lu_sw.a_valid", 64'(a_valid), 64'd0);

    // addi does not read rt
    inst = itype(OpAddi, 2, 7, 16'h0004);
    #1;
    check("lu_addi.a_stall", 64'(a_stall), 64'd0);
    step();
    check("lu_addi.a_valid", 64'(a_valid), 64'd1);

    // load into r0 never stalls
    ex_rt = 5'd0;
    inst  = rtype(0, 0, 1, FnAdd);
    #1;
    check("lu_r0.a_stall", 64'(a_stall), 64'd0);
    check("lu_r0.b_stall", 64'(b_stall), 64'd0);
    step();
    check("lu_r0.a_valid", 64'(a_valid), 64'd1);

    // no stall without a valid instruction
    ex_rt = 5'd7;
    inst  = rtype(7, 7, 1, FnAdd);
    valid = 1'b0;
    #1;
    check("lu_inv.a_stall", 64'(a_stall), 64'd0);
    step();
    check("lu_inv.a_valid", 64'(a_valid), 64'd0);

    // flush with hazard: stall stays asserted, bubble inserted
    valid = 1'b1;
    flush = 1'b1;
    #1;
    check("fl_st.a_stall", 64'(a_stall), 64'd1);
    step();
    check("fl_st.a_valid", 64'(a_valid), 64'd0);
    check("fl_st.a_ctrl", 64'(a_ctrl), 64'd0);

    // flush of a valid lw
    ex_memread = 1'b0;
    ex_rt      = 5'd0;
    inst       = itype(OpLw, 3, 8, 16'h0010);
    #1;
    check("fl_lw.a_stall", 64'(a_stall), 64'd0);
    step();
    check("fl_lw.a_valid", 64'(a_valid), 64'd0);
    check("fl_lw.a_ctrl", 64'(a_ctrl), 64'd0);
    check("fl_lw.b_ctrl", 64'(b_ctrl), 64'd0);
    check("fl_lw.a_illegal", 64'(a_illegal), 64'd0);

    // illegal opcode
    flush = 1'b0;
    inst  = itype(6'h3F, 1, 2, 16'h1234);
    step();
    check("ill_op.a_illegal", 64'(a_illegal), 64'd1);
    check("ill_op.a_ctrl", 64'(a_ctrl), 64'd0);
    check("ill_op.a_valid", 64'(a_valid), 64'd1);
    check("ill_op.b_illegal", 64'(b_illegal), 64'd1);
    check("ill_op.b_valid", 64'(b_valid), 64'd1);

    // unknown R-type funct
    inst = rtype(1, 2, 3, 6'h3F);
    step();
    check("ill_fn.a_illegal", 64'(a_illegal), 64'd1);
    check("ill_fn.a_ctrl", 64'(a_ctrl), 64'd0);

    // legal sub clears illegal
    inst = rtype(1, 2, 3, FnSub);
    step();
    check("sub.a_illegal", 64'(a_illegal), 64'd0);
    check("sub.a_ctrl", 64'(a_ctrl), 64'(CtrlSub));
    check("sub.b_ctrl", 64'(b_ctrl), 64'(CtrlSub));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
